// File: rtl/rv64g_l1_pkg.sv
// Shared constants and types for the banked L1 vector issue path.
// Bank field offset, scheduler FSM states and default geometry.
package rv64g_l1_pkg;

    localparam int BANK_OFS     = 3;
    localparam int NUM_BANKS_D  = 8;
    localparam int NUM_LANES_D  = 8;
    localparam int STARVE_MAX_D = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } sched_state_e;

endpackage

// File: rtl/rv64g_l1_bank_pick.sv
// Lowest-index selector: picks the first pending lane that maps
// onto this bank.
module rv64g_l1_bank_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_pend,
    input  logic [N-1:0] i_match,
    output logic         o_valid,
    output logic [W-1:0] o_idx
);

    logic [N-1:0] w_req;

    assign w_req = i_pend & i_match;

    always_comb begin
        o_valid = |w_req;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req[i]) o_idx = W'(i);
        end
    end

endmodule

// File: rtl/rv64g_l1_bank_scheduler.sv
// Vector lane issue scheduler for the banked L1 arrays: one lane per
// bank per cycle, scalar priority with a starvation override.
module rv64g_l1_bank_scheduler
    import rv64g_l1_pkg::*;
#(
    parameter int NUM_BANKS  = NUM_BANKS_D,
    parameter int NUM_LANES  = NUM_LANES_D,
    parameter int STARVE_MAX = STARVE_MAX_D,
    parameter int BANK_W     = $clog2(NUM_BANKS),
    parameter int LANE_W     = $clog2(NUM_LANES)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        vreq_valid_i,
    output logic                        vreq_ready_o,
    input  logic [NUM_LANES-1:0]        vreq_lane_valid_i,
    input  logic [NUM_LANES*64-1:0]     vreq_lane_addr_i,
    input  logic                        scalar_req_i,
    input  logic [BANK_W-1:0]           scalar_bank_i,
    output logic                        scalar_gnt_o,
    output logic [NUM_BANKS-1:0]        bank_en_o,
    output logic [NUM_BANKS*LANE_W-1:0] bank_lane_o,
    output logic [NUM_LANES-1:0]        lane_issue_o,
    output logic                        vreq_done_o,
    output logic                        busy_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    sched_state_e          r_state;
    sched_state_e          w_state_d;
    logic [NUM_LANES-1:0]  r_pend;
    logic [NUM_LANES-1:0]  w_pend_d;
    logic [BANK_W-1:0]     r_bank [NUM_LANES];
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_BANKS-1:0]  w_cand_v;
    logic [LANE_W-1:0]     w_cand [NUM_BANKS];
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_override;
    logic                  w_gnt;
    logic                  w_unused_addr;

    assign w_busy     = (r_state == ST_BUSY);
    assign w_accept   = vreq_valid_i & (r_state == ST_IDLE);
    assign w_override = w_busy & (r_cnt == CNT_W'(STARVE_MAX));
    assign w_gnt      = scalar_req_i & ~w_override;
    assign scalar_gnt_o = w_gnt;
    assign w_unused_addr = ^vreq_lane_addr_i;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_LANES-1:0] w_match;
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            assign w_match[l] = (r_bank[l] == BANK_W'(b));
        end
        rv64g_l1_bank_pick #(
            .N (NUM_LANES),
            .W (LANE_W)
        ) u_pick (
            .i_pend  (r_pend),
            .i_match (w_match),
            .o_valid (w_cand_v[b]),
            .o_idx   (w_cand[b])
        );
    end

    // Scalar wins its bank unless the starvation override is active.
    always_comb begin
        bank_en_o    = '0;
        bank_lane_o  = '0;
        lane_issue_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_busy && w_cand_v[b] &&
                !(scalar_req_i && scalar_bank_i == BANK_W'(b) && !w_override)) begin
                bank_en_o[b]                      = 1'b1;
                bank_lane_o[b*LANE_W +: LANE_W]   = w_cand[b];
                lane_issue_o[w_cand[b]]           = 1'b1;
            end
        end
    end

    assign w_pend_d = r_pend & ~lane_issue_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            ST_IDLE: if (vreq_valid_i)
                         w_state_d = (|vreq_lane_valid_i) ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_pend_d == '0) w_state_d = ST_DONE;
            ST_DONE: w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vreq_ready_o = (r_state == ST_IDLE);
        busy_o       = (r_state == ST_BUSY) | (r_state == ST_DONE);
        vreq_done_o  = (r_state == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend <= '0;
            for (int l = 0; l < NUM_LANES; l++) r_bank[l] <= '0;
        end else if (w_accept) begin
            r_pend <= vreq_lane_valid_i;
            for (int l = 0; l < NUM_LANES; l++)
                r_bank[l] <= vreq_lane_addr_i[l*64 + BANK_OFS +: BANK_W];
        end else if (w_busy) begin
            r_pend <= w_pend_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_cnt <= '0;
        else if (w_override)
            r_cnt <= '0;
        else if (w_busy && w_gnt && w_cand_v[scalar_bank_i])
            r_cnt <= r_cnt + CNT_W'(1);
        else
            r_cnt <= '0;
    end

endmodule

// File: tb/tb_rv64g_l1_bank_scheduler.sv
// Self-checking bench for rv64g_l1_bank_scheduler: directed scenarios
// plus randomized traffic against a lane/bank behavioural model.
module tb_rv64g_l1_bank_scheduler;

    localparam int NB = 8;
    localparam int NL = 8;
    localparam int SMAX = 4;

    logic           clk;
    logic           rst_n;
    logic           vreq_valid;
    logic           vreq_ready;
    logic [NL-1:0]  vreq_mask;
    logic [NL*64-1:0] vreq_addr;
    logic           scalar_req;
    logic [2:0]     scalar_bank;
    logic           scalar_gnt;
    logic [NB-1:0]  bank_en;
    logic [NB*3-1:0] bank_lane;
    logic [NL-1:0]  lane_issue;
    logic           done;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] addr_tab [NL];

    rv64g_l1_bank_scheduler dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .vreq_valid_i      (vreq_valid),
        .vreq_ready_o      (vreq_ready),
        .vreq_lane_valid_i (vreq_mask),
        .vreq_lane_addr_i  (vreq_addr),
        .scalar_req_i      (scalar_req),
        .scalar_bank_i     (scalar_bank),
        .scalar_gnt_o      (scalar_gnt),
        .bank_en_o         (bank_en),
        .bank_lane_o       (bank_lane),
        .lane_issue_o      (lane_issue),
        .vreq_done_o       (done),
        .busy_o            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request for one cycle; returns at the negedge of T+1.
    task automatic send(input logic [NL-1:0] mask);
        @(negedge clk);
        vreq_valid = 1'b1;
        vreq_mask  = mask;
        for (int l = 0; l < NL; l++) vreq_addr[l*64 +: 64] = addr_tab[l];
        n_checks++;
        if (vreq_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready got=%b exp=1", vreq_ready);
        end
        @(negedge clk);
        vreq_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        scalar_req = 1'b1;
        scalar_bank = 3'd2;
        #1;
        n_checks++;
        if ({vreq_ready, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_status got=%b exp=100", {vreq_ready, busy, done});
        end
        n_checks++;
        if (bank_en !== '0 || lane_issue !== '0 || bank_lane !== '0) begin
            n_fail++;
            $display("FAIL reset_issue en=%h iss=%h lane=%h exp=0", bank_en, lane_issue, bank_lane);
        end
        n_checks++;
        if (scalar_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_gnt got=%b exp=1", scalar_gnt);
        end
        scalar_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unit_stride();
        for (int l = 0; l < NL; l++) addr_tab[l] = 64'h1000 + 64'(l * 8);
        send(8'hFF);
        #1;
        n_checks++;
        if (bank_en !== 8'hFF || lane_issue !== 8'hFF) begin
            n_fail++;
            $display("FAIL unit_issue en=%h iss=%h exp=ff/ff", bank_en, lane_issue);
        end
        n_checks++;
        if (bank_lane !== 24'hFAC688) begin
            n_fail++;
            $display("FAIL unit_lanes got=%h exp=fac688", bank_lane);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({done, busy, vreq_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL unit_done got=%b exp=110", {done, busy, vreq_ready});
        end
        @(negedge clk); #1;
        n_checks++;
        if ({done, busy, vreq_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL unit_idle got=%b exp=001", {done, busy, vreq_ready});
        end
    endtask

    task automatic test_full_conflict();
        for (int l = 0; l < NL; l++) addr_tab[l] = 64'h18;
        send(8'hFF);
        for (int i = 0; i < NL; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            n_checks++;
            if (lane_issue !== 8'(1 << i) || bank_en !== 8'h08 ||
                bank_lane[9 +: 3] !== 3'(i) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL conflict_step%0d iss=%h en=%h lane=%0d done=%b exp iss=%h en=08 lane=%0d",
                         i, lane_issue, bank_en, bank_lane[9 +: 3], done, 8'(1 << i), i);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_done got=%b exp=1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_scalar_priority();
        addr_tab[0] = 64'h40;
        addr_tab[1] = 64'h48;
        send(8'h03);
        scalar_req = 1'b1;
        scalar_bank = 3'd1;
        #1;
        n_checks++;
        if (lane_issue !== 8'h01 || scalar_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_t1 iss=%h gnt=%b exp=01/1", lane_issue, scalar_gnt);
        end
        @(negedge clk);
        scalar_req = 1'b0;
        #1;
        n_checks++;
        if (lane_issue !== 8'h02 || bank_en !== 8'h02) begin
            n_fail++;
            $display("FAIL prio_t2 iss=%h en=%h exp=02/02", lane_issue, bank_en);
        end
        @(negedge clk); #1;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_done got=%b exp=1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        addr_tab[0] = 64'h10;
        send(8'h01);
        scalar_req = 1'b1;
        scalar_bank = 3'd2;
        for (int c = 1; c <= SMAX; c++) begin
            if (c != 1) @(negedge clk);
            #1;
            n_checks++;
            if (scalar_gnt !== 1'b1 || bank_en !== 8'h00 || lane_issue !== 8'h00) begin
                n_fail++;
                $display("FAIL starve_t%0d gnt=%b en=%h iss=%h exp=1/00/00", c, scalar_gnt, bank_en, lane_issue);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (scalar_gnt !== 1'b0 || bank_en !== 8'h04 || lane_issue !== 8'h01) begin
            n_fail++;
            $display("FAIL starve_override gnt=%b en=%h iss=%h exp=0/04/01", scalar_gnt, bank_en, lane_issue);
        end
        @(negedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || scalar_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_done done=%b gnt=%b exp=1/1", done, scalar_gnt);
        end
        scalar_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_empty_backpressure();
        int waited;
        send(8'h00);
        #1;
        n_checks++;
        if (done !== 1'b1 || lane_issue !== 8'h00) begin
            n_fail++;
            $display("FAIL empty_done done=%b iss=%h exp=1/00", done, lane_issue);
        end
        @(negedge clk);
        // first request: two lanes on bank 0 -> issue T+1,T+2, done T+3
        addr_tab[0] = 64'h0;
        addr_tab[1] = 64'h40;
        send(8'h03);
        vreq_valid = 1'b1;
        vreq_mask = 8'h01;
        vreq_addr[63:0] = 64'h28;
        waited = 1;
        #1;
        while (vreq_ready !== 1'b1 && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        n_checks++;
        if (waited != 4) begin
            n_fail++;
            $display("FAIL bp_ready_cycle got=%0d exp=4", waited);
        end
        @(negedge clk);
        vreq_valid = 1'b0;
        #1;
        n_checks++;
        if (lane_issue !== 8'h01 || bank_en !== 8'h20) begin
            n_fail++;
            $display("FAIL bp_second iss=%h en=%h exp=01/20", lane_issue, bank_en);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit saw_done = 0;
        for (int l = 0; l < NL; l++) addr_tab[l] = 64'h18;
        send(8'hFF);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({vreq_ready, busy, done} !== 3'b100 || bank_en !== '0 ||
            lane_issue !== '0 || bank_lane !== '0) begin
            n_fail++;
            $display("FAIL midrst_async st=%b en=%h iss=%h lane=%h exp=100/0/0/0",
                     {vreq_ready, busy, done}, bank_en, lane_issue, bank_lane);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) rst_n = 1'b1;
            #1;
            if (done === 1'b1) saw_done = 1;
        end
        n_checks++;
        if (saw_done || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_nodone saw=%b busy=%b exp=0/0", saw_done, busy);
        end
        for (int l = 0; l < NL; l++) addr_tab[l] = 64'(l * 8);
        send(8'hFF);
        #1;
        n_checks++;
        if (lane_issue !== 8'hFF) begin
            n_fail++;
            $display("FAIL midrst_after iss=%h exp=ff", lane_issue);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            logic [NL-1:0] mpend;
            logic [NL-1:0] exp_iss;
            logic [NB-1:0] exp_en;
            logic [NB*3-1:0] exp_lane;
            int bk [NL];
            int cnt, cyc, found;
            bit sreq, ovr, has, exp_gnt;
            int sb;
            mpend = 8'($urandom);
            if (r % 8 == 0) mpend = '0;
            for (int l = 0; l < NL; l++) begin
                bk[l] = $urandom_range(0, 3);
                addr_tab[l] = {32'($urandom), 32'($urandom)};
                addr_tab[l][5:3] = 3'(bk[l]);
            end
            send(mpend);
            cnt = 0;
            cyc = 0;
            while (mpend != 0 && cyc < 100) begin
                if (cyc != 0) @(negedge clk);
                sreq = ($urandom_range(0, 9) < 7);
                sb = $urandom_range(0, 3);
                scalar_req = sreq;
                scalar_bank = 3'(sb);
                #1;
                ovr = (cnt == SMAX);
                exp_en = '0;
                exp_iss = '0;
                exp_lane = '0;
                has = 0;
                for (int b = 0; b < NB; b++) begin
                    found = -1;
                    for (int l = 0; l < NL; l++)
                        if (mpend[l] && bk[l] == b && found < 0) found = l;
                    if (found >= 0 && b == sb) has = 1;
                    if (found >= 0 && !(sreq && sb == b && !ovr)) begin
                        exp_en[b] = 1'b1;
                        exp_lane[b*3 +: 3] = 3'(found);
                        exp_iss[found] = 1'b1;
                    end
                end
                exp_gnt = sreq && !ovr;
                n_checks++;
                if (bank_en !== exp_en || lane_issue !== exp_iss || bank_lane !== exp_lane ||
                    scalar_gnt !== exp_gnt || busy !== 1'b1 || vreq_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand%0d_c%0d en=%h/%h iss=%h/%h lane=%h/%h gnt=%b/%b busy=%b",
                             r, cyc, bank_en, exp_en, lane_issue, exp_iss,
                             bank_lane, exp_lane, scalar_gnt, exp_gnt, busy);
                end
                cnt = ovr ? 0 : ((exp_gnt && has) ? cnt + 1 : 0);
                mpend &= ~exp_iss;
                cyc++;
            end
            if (mpend != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand%0d_timeout pend=%h exp=00", r, mpend);
            end
            if (cyc != 0) @(negedge clk);
            sreq = $urandom_range(0, 1);
            scalar_req = sreq;
            #1;
            n_checks++;
            if (done !== 1'b1 || scalar_gnt !== sreq || bank_en !== '0) begin
                n_fail++;
                $display("FAIL rand%0d_done done=%b gnt=%b en=%h exp=1/%b/00", r, done, scalar_gnt, bank_en, sreq);
            end
            @(negedge clk);
            scalar_req = 1'b0;
            #1;
            n_checks++;
            if (vreq_ready !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_idle rdy=%b done=%b exp=1/0", r, vreq_ready, done);
            end
        end
    endtask

    initial begin
        vreq_valid = 1'b0;
        vreq_mask = '0;
        vreq_addr = '0;
        scalar_req = 1'b0;
        scalar_bank = '0;
        for (int l = 0; l < NL; l++) addr_tab[l] = '0;
        test_reset();
        test_unit_stride();
        test_full_conflict();
        test_scalar_priority();
        test_starvation();
        test_empty_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv64g_l1_bank_scheduler.md
# rv64g_l1_bank_scheduler

Issue scheduler in front of the banked L1 data/tag arrays. It accepts one vector memory request, up to NUM_LANES lanes, and resolves bank conflicts by issuing at most one lane per bank per cycle, lowest lane index first. It shares each bank with the scalar port: scalar access has priority, and a starvation limiter guarantees vector forward progress. It drives the per-bank enables and lane selects that steer the banked arrays' vector port, and reports per-lane issue and whole-request completion to the VLSU.

## Interface
Parameters:
- NUM_BANKS, 8, number of data banks; power of two; BANK_W = clog2(NUM_BANKS)
- NUM_LANES, 8, vector lanes per request; LANE_W = clog2(NUM_LANES)
- STARVE_MAX, 4, consecutive scalar-blocked cycles tolerated before the vector side takes the contested bank

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk_i  in  1  clock
  - rst_ni  in  1  asynchronous active-low reset
- Vector request:
  - vreq_valid_i  in  1  vector request offered
  - vreq_ready_o  out  1  scheduler idle, request accepted on valid&ready
  - vreq_lane_valid_i  in  NUM_LANES  active lanes of the request
  - vreq_lane_addr_i  in  NUM_LANES*64  lane byte addresses; bank = addr[3 +: BANK_W]
- Scalar port:
  - scalar_req_i  in  1  scalar array access this cycle
  - scalar_bank_i  in  BANK_W  bank targeted by the scalar access (word index)
  - scalar_gnt_o  out  1  scalar access may proceed this cycle
- Vector issue and status:
  - bank_en_o  out  NUM_BANKS  bank b performs a vector access this cycle
  - bank_lane_o  out  NUM_BANKS*LANE_W  lane steered to bank b; 0 when bank_en_o[b]=0
  - lane_issue_o  out  NUM_LANES  lanes issued this cycle
  - vreq_done_o  out  1  one-cycle completion pulse
  - busy_o  out  1  request in flight (state BUSY or DONE)

## Operation
- FSM with three states: IDLE, BUSY, DONE.
- IDLE:
  - vreq_ready_o=1.
  - On accept, capture pending_q = vreq_lane_valid_i and each lane's bank field, then go to BUSY.
  - If the accepted mask is all-zero, go directly to DONE.
- BUSY, each cycle:
  - For each bank b, the candidate is the lowest-index pending lane whose bank equals b.
  - If scalar_req_i and scalar_bank_i==b and no starvation override is active, bank b is withheld from the vector side.
  - Otherwise bank_en_o[b]=1 and bank_lane_o[b]=candidate.
  - lane_issue_o is the OR of all granted lanes.
  - pending_d = pending_q & ~lane_issue_o.
  - When pending_d==0, go to DONE.
- DONE: vreq_done_o=1 for exactly one cycle, then IDLE.
- Scalar grant:
  - scalar_gnt_o = scalar_req_i & ~override.
  - Outside BUSY, override=0, so the scalar port is always granted.
- Starvation counter (width clog2(STARVE_MAX+1)):
  - Increments in a BUSY cycle where the scalar port is granted and its bank holds a pending vector lane.
  - Clears in any other cycle.
  - override is asserted in the cycle where count==STARVE_MAX: the vector lane takes the bank and scalar_gnt_o=0.
  - The counter clears in that same cycle.
- A vreq_valid_i presented while not IDLE is held off (ready=0); the request is not dropped.
- Lanes hitting distinct banks all issue in the same cycle. Lanes sharing a bank issue in ascending lane order, one per cycle.

## Timing
- Reset values:
  - state=IDLE, pending_q=0, counter=0.
  - vreq_ready_o=1, busy_o=0, vreq_done_o=0, bank_en_o=0, bank_lane_o=0, lane_issue_o=0.
  - scalar_gnt_o follows scalar_req_i.
- Reset mid-request aborts immediately: pending lanes are discarded and no done pulse is produced.
- Signal timing:
  - bank_en_o, bank_lane_o, lane_issue_o and scalar_gnt_o are combinational from registered state plus the scalar inputs.
  - vreq_ready_o, busy_o and vreq_done_o are decoded from the state register only.
- Latency with accept at edge T:
  - First issue occurs in cycle T+1.
  - With k = max lanes per bank, the last issue is in cycle T+k, done in T+k+1, ready in T+k+2.
  - No conflicts: issue T+1, done T+2.
  - All 8 lanes on one bank: issue T+1..T+8, done T+9.
  - Empty mask: done T+1.
- Each scalar-forced stall adds one cycle to vector completion. With a continuous scalar stream on a contested bank, vector lanes to that bank issue at least once every STARVE_MAX+1 cycles.

## Structure
- Shared package rv64g_l1_pkg holds:
  - the bank-field offset constant (3);
  - the FSM state enum;
  - the default NUM_BANKS, NUM_LANES and STARVE_MAX localparams.
- Sub-module rv64g_l1_bank_pick: lowest-index one-of-N selector taking the pending mask and the per-lane bank match for one bank, returning valid plus lane index. It is instantiated NUM_BANKS times in a generate loop.
- The FSM, pending register, starvation counter and scalar arbitration live in the top module.

## Test plan
- Unit-stride: 8 lanes, addr[5:3]=0..7, no scalar traffic -> bank_en_o=0xFF in T+1, lane_issue_o=0xFF, done pulse T+2.
- Full conflict: all lanes addr 0x18 (bank 3) -> lane_issue_o=0x01,0x02,…,0x80 in T+1..T+8, bank_lane_o[3]=0..7, done T+9.
- Scalar priority: mask 0x03, lanes on banks 0 and 1, scalar_req_i=1 bank 1 for one cycle at T+1 -> T+1 issue 0x01 with scalar_gnt_o=1; T+2 issue 0x02; done T+3.
- Starvation: STARVE_MAX=4, one lane on bank 2, scalar_req_i held on bank 2 -> scalar_gnt_o=1 for T+1..T+4, 0 at T+5 with bank_en_o[2]=1, done T+6.
- Empty mask and back-pressure: accept mask 0x00 -> done T+1. Second vreq_valid_i during BUSY -> not accepted until ready returns.
- Reset mid-request: assert rst_ni=0 during BUSY of the full-conflict case -> all outputs return to reset values asynchronously, no done pulse, a new request is accepted normally after release.
